// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Optional per-requester transfer counters are enabled by defining FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_we,
    output logic [WIDTH-1:0]         fifo_din,
    input  logic                     fifo_full,
    input  logic [WIDTH-1:0]         fifo_count,
    output logic [IDW-1:0]           last_id,
    output logic                     busy
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

    localparam int unsigned CW = 16;

    logic               space_c;
    logic               found_c;
    logic               xfer_c;
    logic [IDW-1:0]     grant_id_c;
    logic [IDW-1:0]     idx_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [WIDTH-1:0]   sel_data_c;

    // A write registered last cycle is not yet visible in fifo_count, so reserve its slot.
    assign space_c = !fifo_full && !(fifo_we && (fifo_count == WIDTH'(DEPTH - 1)));

    // Cyclic search starting just after the most recently granted requester.
    always_comb begin
        found_c    = 1'b0;
        grant_id_c = last_id;
        idx_c      = last_id;
        grant_c    = '0;
        if (!reset && space_c) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx_c = last_id + IDW'(k);
                if (!found_c && req_valid[idx_c]) begin
                    found_c    = 1'b1;
                    grant_id_c = idx_c;
                end
            end
        end
        if (found_c) begin
            grant_c[grant_id_c] = 1'b1;
        end
    end

    assign req_ready = grant_c;
    assign xfer_c    = |(req_valid & grant_c);

    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_data_c = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_we  <= 1'b0;
            fifo_din <= '0;
            last_id  <= IDW'(NUM_REQ - 1);
            busy     <= 1'b0;
        end else begin
            busy    <= (|req_valid) || fifo_we;
            fifo_we <= xfer_c;
            if (xfer_c) begin
                fifo_din <= sel_data_c;
                last_id  <= grant_id_c;
            end
        end
    end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    // Per-requester transfer counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && grant_c[i]) begin
                    grant_cnt[i*CW +: CW] <= grant_cnt[i*CW +: CW] + CW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed table, corner sequences and random traffic
// against an occupancy/round-robin reference model.
module tb_fifo_write_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned D   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_we;
    logic [W-1:0]   fifo_din;
    logic           fifo_full;
    logic [W-1:0]   fifo_count;
    logic [IDW-1:0] last_id;
    logic           busy;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [N*16-1:0] grant_cnt;
    int unsigned     m_cnt [N];
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int       m_last;
    bit       m_we;
    bit [W-1:0] m_din;
    int       m_count;
    int       dut_writes;

    fifo_write_arbiter #(.WIDTH(W), .DEPTH(D), .NUM_REQ(N), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .last_id   (last_id),
        .busy      (busy)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        logic         full;
        logic [W-1:0] cnt;
        logic [N-1:0] ready;
        logic         we;
        logic [W-1:0] din;
        logic [1:0]   last;
        logic         busy;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // First valid requester after 'last' in cyclic order, or -1.
    function automatic int model_grant(input logic [N-1:0] v, input int last, input bit space);
        if (!space) return -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_init();
        m_last  = N - 1;
        m_we    = 0;
        m_din   = '0;
        m_count = 0;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    endtask

    // Reset with requests pending; outputs must hold reset values. Ends at posedge+1, reset low.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_data  = '0;
        fifo_full = 1'b0;
        fifo_count = '0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_we", 64'(fifo_we), 64'd0);
        chk("rst_din", 64'(fifo_din), 64'd0);
        chk("rst_last", 64'(last_id), 64'd3);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
`endif
        reset = 1'b0;
        req_valid = '0;
        model_init();
    endtask

    // One model-checked cycle; call at posedge+1, returns at next posedge+1.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit rd);
        bit space;
        int gi;
        bit exp_busy;
        logic [N-1:0] exp_ready;
        req_valid  = v;
        req_data   = d;
        fifo_full  = (m_count == D);
        fifo_count = W'(m_count);
        #1;
        space = (m_count != D) && !(m_we && m_count == D - 1);
        gi = model_grant(v, m_last, space);
        exp_ready = '0;
        if (gi >= 0) exp_ready[gi] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        exp_busy = (|v) || m_we;
        chk("no_overflow", 64'(m_we && m_count == D), 64'd0);
        m_count = m_count + (m_we ? 1 : 0);
        if (m_count > D) m_count = D;
        if (rd && m_count > 0) m_count--;
        m_we = (gi >= 0);
        if (gi >= 0) begin
            m_din  = d[gi*W +: W];
            m_last = gi;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
            m_cnt[gi] = (m_cnt[gi] + 1) % 65536;
`endif
        end
        if (fifo_we === 1'b1) dut_writes++;
        chk("fifo_we", 64'(fifo_we), 64'(m_we));
        chk("fifo_din", 64'(fifo_din), 64'(m_din));
        chk("last_id", 64'(last_id), 64'(m_last));
        chk("busy", 64'(busy), 64'(exp_busy));
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    endtask

    initial begin
        logic [N*W-1:0] td;
        logic [N*W-1:0] rdata;
        td = {16'h3333, 16'h2222, 16'hA5A5, 16'h1111};

        // Directed vectors: FIFO flags driven straight from the table.
        tbl[0]  = '{4'b0010, 1'b0, 16'd0, 4'b0010, 1'b1, 16'hA5A5, 2'd1, 1'b1};
        tbl[1]  = '{4'b0000, 1'b0, 16'd1, 4'b0000, 1'b0, 16'hA5A5, 2'd1, 1'b1};
        tbl[2]  = '{4'b1001, 1'b0, 16'd1, 4'b1000, 1'b1, 16'h3333, 2'd3, 1'b1};
        tbl[3]  = '{4'b1001, 1'b0, 16'd2, 4'b0001, 1'b1, 16'h1111, 2'd0, 1'b1};
        tbl[4]  = '{4'b1001, 1'b0, 16'd3, 4'b1000, 1'b1, 16'h3333, 2'd3, 1'b1};
        tbl[5]  = '{4'b1111, 1'b0, 16'd7, 4'b0000, 1'b0, 16'h3333, 2'd3, 1'b1};
        tbl[6]  = '{4'b1111, 1'b0, 16'd7, 4'b0001, 1'b1, 16'h1111, 2'd0, 1'b1};
        tbl[7]  = '{4'b1111, 1'b1, 16'd8, 4'b0000, 1'b0, 16'h1111, 2'd0, 1'b1};
        tbl[8]  = '{4'b1111, 1'b0, 16'd7, 4'b0010, 1'b1, 16'hA5A5, 2'd1, 1'b1};
        tbl[9]  = '{4'b0000, 1'b0, 16'd0, 4'b0000, 1'b0, 16'hA5A5, 2'd1, 1'b1};
        tbl[10] = '{4'b0000, 1'b0, 16'd0, 4'b0000, 1'b0, 16'hA5A5, 2'd1, 1'b0};

        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        fifo_full = 1'b0;
        fifo_count = '0;
        #12;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            req_valid  = tbl[i].v;
            req_data   = td;
            fifo_full  = tbl[i].full;
            fifo_count = tbl[i].cnt;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_we", i), 64'(fifo_we), 64'(tbl[i].we));
            chk($sformatf("tbl%0d_din", i), 64'(fifo_din), 64'(tbl[i].din));
            chk($sformatf("tbl%0d_last", i), 64'(last_id), 64'(tbl[i].last));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
        end

        // Round-robin fill of an empty FIFO with no reads: 0,1,2,3,0,1,2,3 then stall.
        do_reset();
        dut_writes = 0;
        for (int c = 0; c < 14; c++) begin
            cycle(4'b1111, td, 1'b0);
            if (c < 4) chk("rr_order", 64'(last_id), 64'(c));
        end
        chk("rr_total_writes", 64'(dut_writes), 64'd8);
        chk("rr_fifo_full_cnt", 64'(m_count), 64'd8);

        // Skip idle requesters with reads keeping space.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(4'b1001, td, 1'b1);
            chk("skip_idle_id", 64'(last_id == 2'd1 || last_id == 2'd2), 64'd0);
        end

        // Async reset while a write is pending.
        do_reset();
        cycle(4'b1111, td, 1'b1);
        cycle(4'b1111, td, 1'b1);
        chk("mid_we_before", 64'(fifo_we), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 64'(fifo_we), 64'd0);
        chk("mid_rst_last", 64'(last_id), 64'd3);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
        cycle(4'b1111, td, 1'b0);
        chk("mid_first_grant", 64'(last_id), 64'd0);

`ifdef FIFO_WRITE_ARBITER_STATS_EN
        // Five transfers from requester 2 only.
        do_reset();
        for (int c = 0; c < 5; c++) cycle(4'b0100, td, 1'b1);
        cycle(4'b0000, td, 1'b1);
        chk("stats_req2", 64'(grant_cnt), 64'h0000_0005_0000_0000);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdata = {$urandom(), $urandom()};
            cycle(N'($urandom_range(0, 15)), rdata, ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter that shares one simple_fifo write port between NUM_REQ producers.
- Each producer has a valid/ready port; the arbiter grants one producer per cycle and drives registered we/din into the FIFO.
- Uses the FIFO full/count outputs so the FIFO never overflows, including the write already in flight.

Parameters:
- WIDTH, 16, data width; matches the FIFO WIDTH.
- DEPTH, 8, FIFO depth; matches the FIFO DEPTH.
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- IDW, 2, grant index width; equals log2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*WIDTH  requester i data occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- fifo_we  out  1  FIFO write enable; registered.
- fifo_din  out  WIDTH  FIFO write data; registered.
- fifo_full  in  1  FIFO full flag.
- fifo_count  in  WIDTH  FIFO occupancy.
- last_id  out  IDW  index of the most recently granted requester; registered.
- busy  out  1  high while any req_valid is high or fifo_we is high.

Behaviour:
- Reset values (asynchronous, immediate):
  - fifo_we=0, fifo_din=0, last_id=NUM_REQ-1.
  - Round-robin pointer equals last_id, so the first search starts at requester 0.
  - req_ready=0 while reset is high.
- Space check (combinational): space = !fifo_full && !(fifo_we && fifo_count == DEPTH-1).
  - This covers the write registered in the previous cycle that the FIFO has not yet reflected.
- Grant (combinational):
  - If space, search req_valid cyclically from last_id+1 (mod NUM_REQ).
  - The first set bit i gets req_ready[i]=1; all other bits are 0.
  - If no space or no valid, req_ready=0.
- Transfer: a transfer occurs when req_valid[i] && req_ready[i] at a rising edge.
- On a transfer to requester i, at the next edge:
  - fifo_we=1, fifo_din=req_data[i], last_id=i.
- With no transfer, fifo_we=0, and fifo_din and last_id hold.
- Latency: one cycle from handshake to FIFO write. Throughput: one word per cycle while space holds.
- Fairness:
  - A requester that was just granted is searched last next cycle.
  - With all requesters valid and continuous space, the grant sequence is 0,1,2,…,NUM_REQ-1,0,…
  - Any valid requester is granted within NUM_REQ accepted transfers.
- Requesters must hold req_valid and req_data stable until ready. A requester that drops valid before grant loses nothing; it is simply skipped.
- Full boundary:
  - With fifo_count = DEPTH-1 and fifo_we = 1 in the same cycle, there are no grants that cycle.
  - With fifo_full=1, there are no grants.
  - Grants resume in the first cycle space is true.
- The FIFO read side is independent. A read in the same cycle as full deasserts fifo_full next cycle; the arbiter reacts combinationally then.
- Reset mid-operation: a pending registered write is dropped (fifo_we forced 0), and the pointer returns to requester 0 priority.
- busy is registered: busy = |req_valid || fifo_we, sampled each edge; reset value 0.

Optional Feature:
- Macro: FIFO_WRITE_ARBITER_STATS_EN.
- When defined, adds output port grant_cnt [NUM_REQ*16].
  - One 16-bit counter per requester, incremented on each of that requester's transfers.
  - Counters wrap from 0xFFFF to 0 and reset to 0.
- When undefined, the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester: reset, then req_valid=4'b0010 with req_data[1]=16'hA5A5 for one handshake → req_ready=4'b0010 that cycle; next cycle fifo_we=1, fifo_din=16'hA5A5, last_id=1.
- Round-robin: all four valid continuously with an empty FIFO and the read side idle → grants 0,1,2,3, then no grant once count reaches 8; exactly 8 writes total, no overflow.
- In-flight boundary: fifo_count=7 with a write registered this cycle → req_ready=0 this cycle even though fifo_full=0; after one read, grant resumes.
- Skip idle: req_valid=4'b1001 continuous → grant order 0,3,0,3,…; requesters 1 and 2 never granted.
- Async reset mid-burst: assert reset between edges while fifo_we=1 → fifo_we drops immediately, last_id=3; after release with all valid, the first grant goes to requester 0.
- With FIFO_WRITE_ARBITER_STATS_EN: 5 transfers from requester 2 → grant_cnt[47:32]=5, other counters 0; reset clears all counters.
